// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared port map, CRTC indexes, SD command codes and interrupt defaults
package io_pkg;

  localparam logic [15:0] PORT_PIC_CMD   = 16'h0020;
  localparam logic [15:0] PORT_PIC_MASK  = 16'h0021;
  localparam logic [15:0] PORT_KBD_DATA  = 16'h0060;
  localparam logic [15:0] PORT_KBD_STAT  = 16'h0064;
  localparam logic [15:0] PORT_DAC_IDX   = 16'h03C8;
  localparam logic [15:0] PORT_DAC_DATA  = 16'h03C9;
  localparam logic [15:0] PORT_CRTC_IDX  = 16'h03D4;
  localparam logic [15:0] PORT_CRTC_DATA = 16'h03D5;
  localparam logic [15:0] PORT_SD_DATA   = 16'h00FE;
  localparam logic [15:0] PORT_SD_CMD    = 16'h00FF;

  localparam logic [7:0] CRTC_CURSOR_HI = 8'h0E;
  localparam logic [7:0] CRTC_CURSOR_LO = 8'h0F;

  localparam logic [7:0] INT_BASE_DEFAULT = 8'h08;

  typedef enum logic [1:0] {
    SD_NOP        = 2'd0,
    SD_XFER       = 2'd1,
    SD_CS_ASSERT  = 2'd2,
    SD_CS_RELEASE = 2'd3
  } sd_cmd_t;

endpackage

// File: rtl/port_irq_arbiter.sv
// rtl/port_irq_arbiter.sv - pending/mask registers and fixed-priority vector encoder (IRQ0 highest)
module port_irq_arbiter #(
  parameter logic [7:0] INT_BASE = io_pkg::INT_BASE_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] set,
  input  logic       mask_we,
  input  logic [7:0] mask_data,
  input  logic       intr_latch,
  output logic [7:0] mask,
  output logic       intr,
  output logic [7:0] irq
);

  logic [7:0] pending;
  logic [7:0] req;
  logic [7:0] clr;
  logic [2:0] idx;

  assign req  = pending & ~mask;
  assign intr = |req;

  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

  assign irq = intr ? (INT_BASE + {5'b0, idx}) : 8'h00;
  assign clr = (intr_latch && intr) ? (8'b1 << idx) : 8'h00;

  // OR-ing set after the clear lets a new request survive a same-cycle acknowledge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 8'h00;
      mask    <= 8'hFF;
    end else begin
      pending <= (pending & ~clr) | set;
      if (mask_we) mask <= mask_data;
    end
  end

endmodule

// File: rtl/port_controller.sv
// rtl/port_controller.sv - I/O port decoder for keyboard, CRTC cursor, DAC palette, SD and interrupts
module port_controller #(
  parameter int         TIMER_DIV = 1373626,
  parameter logic [7:0] INT_BASE  = io_pkg::INT_BASE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        port_clk,
  input  logic [15:0] port,
  output logic [7:0]  port_i,
  input  logic [7:0]  port_o,
  input  logic        port_w,
  output logic [10:0] vga_cursor,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_hit,
  output logic [31:0] dac_out,
  output logic [7:0]  dac_address,
  output logic        dac_we,
  output logic        sd_signal,
  output logic [1:0]  sd_cmd,
  input  logic [7:0]  sd_din,
  output logic [7:0]  sd_out,
  input  logic        sd_busy,
  input  logic        sd_timeout,
  output logic        intr,
  output logic [7:0]  irq,
  input  logic        intr_latch
);
  import io_pkg::*;

  localparam int TW = (TIMER_DIV > 2) ? $clog2(TIMER_DIV) : 1;

  logic          wr, rd;
  logic [7:0]    rd_data, crtc_rd;
  logic [7:0]    kbd_data, crtc_idx, dac_r, dac_g, mask;
  logic          kbd_full;
  logic [1:0]    rgb_cnt;
  sd_cmd_t       sd_cmd_q;
  logic [TW-1:0] tmr_cnt;
  logic          tick;

  assign wr     = port_clk && port_w;
  assign rd     = port_clk && !port_w;
  assign sd_cmd = sd_cmd_q;
  assign tick   = (tmr_cnt == TW'(TIMER_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tmr_cnt <= '0;
    else          tmr_cnt <= tick ? '0 : tmr_cnt + TW'(1);
  end

  port_irq_arbiter #(.INT_BASE(INT_BASE)) u_irq (
    .clock      (clock),
    .reset_n    (reset_n),
    .set        ({6'b0, ps2_hit, tick}),
    .mask_we    (wr && (port == PORT_PIC_MASK)),
    .mask_data  (port_o),
    .intr_latch (intr_latch),
    .mask       (mask),
    .intr       (intr),
    .irq        (irq)
  );

  assign crtc_rd = (crtc_idx == CRTC_CURSOR_HI) ? {5'b0, vga_cursor[10:8]} :
                   (crtc_idx == CRTC_CURSOR_LO) ? vga_cursor[7:0] : 8'h00;

  always_comb begin
    rd_data = 8'hFF;
    case (port)
      PORT_PIC_MASK:  rd_data = mask;
      PORT_KBD_DATA:  rd_data = kbd_data;
      PORT_KBD_STAT:  rd_data = {7'b0, kbd_full};
      PORT_CRTC_IDX:  rd_data = crtc_idx;
      PORT_CRTC_DATA: rd_data = crtc_rd;
      PORT_SD_DATA:   rd_data = sd_din;
      PORT_SD_CMD:    rd_data = {6'b0, sd_timeout, sd_busy};
      default:        rd_data = 8'hFF;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      port_i      <= 8'hFF;
      vga_cursor  <= '0;
      dac_out     <= '0;
      dac_address <= '0;
      dac_we      <= 1'b0;
      sd_signal   <= 1'b0;
      sd_cmd_q    <= SD_NOP;
      sd_out      <= '0;
      kbd_data    <= '0;
      kbd_full    <= 1'b0;
      crtc_idx    <= '0;
      rgb_cnt     <= '0;
      dac_r       <= '0;
      dac_g       <= '0;
    end else begin
      dac_we    <= 1'b0;
      sd_signal <= 1'b0;
      if (rd) port_i <= rd_data;
      // Palette index advances the edge after the write pulse; an index write on that edge wins
      if (dac_we) dac_address <= dac_address + 8'd1;
      if (ps2_hit) begin
        kbd_data <= ps2_data;
        kbd_full <= 1'b1;
      end else if (rd && (port == PORT_KBD_DATA)) begin
        kbd_full <= 1'b0;
      end
      if (wr) begin
        case (port)
          PORT_PIC_CMD: ;
          PORT_DAC_IDX: begin
            dac_address <= port_o;
            rgb_cnt     <= 2'd0;
          end
          PORT_DAC_DATA: begin
            case (rgb_cnt)
              2'd0: begin dac_r <= port_o; rgb_cnt <= 2'd1; end
              2'd1: begin dac_g <= port_o; rgb_cnt <= 2'd2; end
              default: begin
                dac_out <= {8'h00, dac_r, dac_g, port_o};
                dac_we  <= 1'b1;
                rgb_cnt <= 2'd0;
              end
            endcase
          end
          PORT_CRTC_IDX: crtc_idx <= port_o;
          PORT_CRTC_DATA: begin
            if (crtc_idx == CRTC_CURSOR_HI)      vga_cursor[10:8] <= port_o[2:0];
            else if (crtc_idx == CRTC_CURSOR_LO) vga_cursor[7:0]  <= port_o;
          end
          PORT_SD_DATA: sd_out <= port_o;
          PORT_SD_CMD: begin
            sd_cmd_q  <= sd_cmd_t'(port_o[1:0]);
            sd_signal <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_port_controller.sv
// tb/tb_port_controller.sv - scoreboard bench for port_controller with directed port accesses
module tb_port_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        port_clk = 1'b0;
  logic [15:0] port = 16'h0000;
  logic [7:0]  port_i;
  logic [7:0]  port_o = 8'h00;
  logic        port_w = 1'b0;
  logic [10:0] vga_cursor;
  logic [7:0]  ps2_data = 8'h00;
  logic        ps2_hit = 1'b0;
  logic [31:0] dac_out;
  logic [7:0]  dac_address;
  logic        dac_we;
  logic        sd_signal;
  logic [1:0]  sd_cmd;
  logic [7:0]  sd_din = 8'h00;
  logic [7:0]  sd_out;
  logic        sd_busy = 1'b0;
  logic        sd_timeout = 1'b0;
  logic        intr;
  logic [7:0]  irq;
  logic        intr_latch = 1'b0;

  localparam int S_PORT_I = 0, S_INTR = 1, S_IRQ = 2, S_CURSOR = 3, S_DAC_ADDR = 4;
  localparam int S_DAC_WE = 5, S_SD_OUT = 6, S_SD_CMD = 7, S_SD_SIG = 8;

  int checks = 0;
  int passes = 0;
  int dac_pulses = 0, sd_pulses = 0, exp_dac_pulses = 0, exp_sd_pulses = 0;
  int tcnt;

  logic [7:0]  rd_exp_q[$];
  string       rd_name_q[$];
  logic [39:0] dac_q[$];
  logic [9:0]  sd_q[$];
  int          probe_sel_q[$];
  logic [31:0] probe_exp_q[$];
  string       probe_name_q[$];

  logic rd_seen = 1'b0;
  logic prev_dac_we = 1'b0;
  logic prev_sd_signal = 1'b0;

  always #5 clock = ~clock;

  port_controller #(.TIMER_DIV(4), .INT_BASE(8'h08)) dut (
    .clock(clock), .reset_n(reset_n), .port_clk(port_clk), .port(port),
    .port_i(port_i), .port_o(port_o), .port_w(port_w), .vga_cursor(vga_cursor),
    .ps2_data(ps2_data), .ps2_hit(ps2_hit), .dac_out(dac_out),
    .dac_address(dac_address), .dac_we(dac_we), .sd_signal(sd_signal),
    .sd_cmd(sd_cmd), .sd_din(sd_din), .sd_out(sd_out), .sd_busy(sd_busy),
    .sd_timeout(sd_timeout), .intr(intr), .irq(irq), .intr_latch(intr_latch)
  );

  // Free-running tick phase so stimulus can line up a keyboard hit with a timer wrap
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) tcnt <= 0;
    else          tcnt <= (tcnt == 3) ? 0 : tcnt + 1;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic logic [31:0] probe_value(int sel);
    case (sel)
      S_PORT_I:   return 32'(port_i);
      S_INTR:     return 32'(intr);
      S_IRQ:      return 32'(irq);
      S_CURSOR:   return 32'(vga_cursor);
      S_DAC_ADDR: return 32'(dac_address);
      S_DAC_WE:   return 32'(dac_we);
      S_SD_OUT:   return 32'(sd_out);
      S_SD_CMD:   return 32'(sd_cmd);
      default:    return 32'(sd_signal);
    endcase
  endfunction

  always @(posedge clock) rd_seen <= reset_n && port_clk && !port_w;

  always @(negedge clock) begin
    if (rd_seen) begin
      check("read_expected", 32'(rd_exp_q.size() > 0), 32'd1);
      if (rd_exp_q.size() > 0) check(rd_name_q.pop_front(), 32'(port_i), 32'(rd_exp_q.pop_front()));
    end
    if (dac_we) begin
      dac_pulses++;
      check("dac_we_width", 32'(prev_dac_we), 32'd0);
      check("dac_we_expected", 32'(dac_q.size() > 0), 32'd1);
      if (dac_q.size() > 0) begin
        logic [39:0] e;
        e = dac_q.pop_front();
        check("dac_out", dac_out, e[39:8]);
        check("dac_address_at_we", 32'(dac_address), 32'(e[7:0]));
      end
    end
    if (sd_signal) begin
      sd_pulses++;
      check("sd_signal_width", 32'(prev_sd_signal), 32'd0);
      check("sd_signal_expected", 32'(sd_q.size() > 0), 32'd1);
      if (sd_q.size() > 0) begin
        logic [9:0] e;
        e = sd_q.pop_front();
        check("sd_cmd_at_signal", 32'(sd_cmd), 32'(e[9:8]));
        check("sd_out_at_signal", 32'(sd_out), 32'(e[7:0]));
      end
    end
    prev_dac_we    = dac_we;
    prev_sd_signal = sd_signal;
    while (probe_sel_q.size() > 0) begin
      int sel;
      sel = probe_sel_q.pop_front();
      check(probe_name_q.pop_front(), probe_value(sel), probe_exp_q.pop_front());
    end
  end

  task automatic tick_n(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus(logic w, logic [15:0] a, logic [7:0] d);
    port_clk = 1'b1; port_w = w; port = a; port_o = d;
    tick_n(1);
    port_clk = 1'b0; port_w = 1'b0;
  endtask

  task automatic out_b(logic [15:0] a, logic [7:0] d);
    bus(1'b1, a, d);
  endtask

  task automatic in_b(string name, logic [15:0] a, logic [7:0] exp);
    rd_name_q.push_back(name);
    rd_exp_q.push_back(exp);
    bus(1'b0, a, 8'h00);
  endtask

  task automatic expect_state(string name, int sel, logic [31:0] exp);
    probe_name_q.push_back(name);
    probe_sel_q.push_back(sel);
    probe_exp_q.push_back(exp);
  endtask

  task automatic pulse_latch();
    intr_latch = 1'b1; tick_n(1); intr_latch = 1'b0;
  endtask

  task automatic pulse_hit(logic [7:0] d);
    ps2_data = d; ps2_hit = 1'b1; tick_n(1); ps2_hit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    tick_n(3);
    reset_n = 1'b1;
    expect_state("reset_port_i", S_PORT_I, 32'hFF);
    expect_state("reset_intr", S_INTR, 32'h0);
    expect_state("reset_irq", S_IRQ, 32'h0);
    expect_state("reset_cursor", S_CURSOR, 32'h0);
    expect_state("reset_dac_we", S_DAC_WE, 32'h0);
    expect_state("reset_dac_addr", S_DAC_ADDR, 32'h0);
    expect_state("reset_sd_signal", S_SD_SIG, 32'h0);
    tick_n(1);
    in_b("unmapped_read", 16'h1234, 8'hFF);

    out_b(16'h03D4, 8'h0E); out_b(16'h03D5, 8'h05);
    out_b(16'h03D4, 8'h0F); out_b(16'h03D5, 8'h50);
    expect_state("cursor_550", S_CURSOR, 32'h550);
    in_b("crtc_lo_read", 16'h03D5, 8'h50);
    in_b("crtc_idx_read", 16'h03D4, 8'h0F);
    out_b(16'h03D4, 8'h0E);
    in_b("crtc_hi_read", 16'h03D5, 8'h05);
    out_b(16'h03D4, 8'h10); out_b(16'h03D5, 8'hAA);
    expect_state("cursor_other_idx", S_CURSOR, 32'h550);
    in_b("crtc_other_read", 16'h03D5, 8'h00);

    out_b(16'h03C8, 8'hFF);
    expect_state("dac_idx_ff", S_DAC_ADDR, 32'hFF);
    dac_q.push_back({32'h00112233, 8'hFF}); exp_dac_pulses++;
    out_b(16'h03C9, 8'h11); out_b(16'h03C9, 8'h22); out_b(16'h03C9, 8'h33);
    tick_n(1);
    expect_state("dac_addr_wrap", S_DAC_ADDR, 32'h00);
    out_b(16'h03C8, 8'h10); out_b(16'h03C9, 8'h01);
    out_b(16'h03C8, 8'h20);
    dac_q.push_back({32'h00AABBCC, 8'h20}); exp_dac_pulses++;
    out_b(16'h03C9, 8'hAA); out_b(16'h03C9, 8'hBB); out_b(16'h03C9, 8'hCC);
    tick_n(1);
    expect_state("dac_addr_inc", S_DAC_ADDR, 32'h21);

    out_b(16'h0021, 8'hFD);
    in_b("mask_read", 16'h0021, 8'hFD);
    pulse_hit(8'h1E);
    expect_state("kbd_intr", S_INTR, 32'h1);
    expect_state("kbd_irq", S_IRQ, 32'h09);
    pulse_latch();
    expect_state("kbd_intr_cleared", S_INTR, 32'h0);
    in_b("kbd_stat_full", 16'h0064, 8'h01);
    in_b("kbd_data", 16'h0060, 8'h1E);
    in_b("kbd_stat_empty", 16'h0064, 8'h00);
    pulse_hit(8'h2C);
    ps2_data = 8'h3D; ps2_hit = 1'b1;
    in_b("kbd_hit_during_read", 16'h0060, 8'h2C);
    ps2_hit = 1'b0;
    in_b("kbd_stat_still_full", 16'h0064, 8'h01);
    in_b("kbd_new_byte", 16'h0060, 8'h3D);
    pulse_latch();
    expect_state("kbd_intr_cleared2", S_INTR, 32'h0);

    out_b(16'h0021, 8'h00);
    for (int k = 0; k < 8 && tcnt != 3; k++) tick_n(1);
    pulse_hit(8'h55);
    expect_state("both_intr", S_INTR, 32'h1);
    expect_state("both_irq_timer_first", S_IRQ, 32'h08);
    pulse_latch();
    expect_state("both_irq_kbd_second", S_IRQ, 32'h09);
    pulse_latch();
    expect_state("both_intr_cleared", S_INTR, 32'h0);
    out_b(16'h0021, 8'hFF);
    tick_n(2);
    out_b(16'h0021, 8'hFE);
    expect_state("unmask_pending_irq", S_IRQ, 32'h08);
    out_b(16'h0021, 8'hFF);
    expect_state("remask_intr", S_INTR, 32'h0);

    out_b(16'h00FE, 8'hA5);
    expect_state("sd_out", S_SD_OUT, 32'hA5);
    sd_q.push_back({2'd1, 8'hA5}); exp_sd_pulses++;
    out_b(16'h00FF, 8'h01);
    expect_state("sd_cmd_held", S_SD_CMD, 32'h1);
    sd_busy = 1'b1; sd_timeout = 1'b1;
    in_b("sd_status", 16'h00FF, 8'h03);
    sd_din = 8'h5A;
    in_b("sd_din", 16'h00FE, 8'h5A);
    sd_q.push_back({2'd3, 8'hA5}); exp_sd_pulses++;
    out_b(16'h00FF, 8'h03);
    sd_busy = 1'b0; sd_timeout = 1'b0;
    tick_n(1);

    out_b(16'h03C8, 8'h40); out_b(16'h03C9, 8'h01); out_b(16'h03C9, 8'h02);
    out_b(16'h03C9, 8'h03);
    reset_n = 1'b0;
    tick_n(2);
    reset_n = 1'b1;
    expect_state("rst_dac_we", S_DAC_WE, 32'h0);
    expect_state("rst_dac_addr", S_DAC_ADDR, 32'h0);
    expect_state("rst_cursor", S_CURSOR, 32'h0);
    expect_state("rst_port_i", S_PORT_I, 32'hFF);
    expect_state("rst_sd_cmd", S_SD_CMD, 32'h0);
    tick_n(1);
    in_b("rst_mask", 16'h0021, 8'hFF);
    in_b("rst_kbd_stat", 16'h0064, 8'h00);
    tick_n(3);

    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
    check("dac_queue_drained", 32'(dac_q.size()), 32'd0);
    check("sd_queue_drained", 32'(sd_q.size()), 32'd0);
    check("dac_pulse_count", 32'(dac_pulses), 32'(exp_dac_pulses));
    check("sd_pulse_count", 32'(sd_pulses), 32'(exp_sd_pulses));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
